// File: rtl/count_seq_pkg.sv
// count_seq_pkg
//   Shared definitions for the count sequence monitor.
//   - state_e : monitor FSM encodings (2'd3 is unused and recovers to idle)
//   - BCD_MAX : largest value of one BCD decade
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/count_seq_monitor_bcd_digit_counter.sv
// bcd_digit_counter
//   One decade of a packed-BCD tally. The digit advances on inc and rolls
//   9 -> 0, raising carry in the same cycle so decades can be chained
//   without adding latency.
// Ports
//   clk   in  1  clock, posedge
//   rst   in  1  synchronous active-low reset
//   inc   in  1  advance this digit by one
//   digit out 4  registered decade value 0..9
//   carry out 1  inc while digit is 9 (rolls the next decade)
module bcd_digit_counter
  import count_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_r;

  // Decade register: clear on reset, advance with 9 -> 0 rollover.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_r <= 4'd0;
    end else if (inc) begin
      if (digit_r == BCD_MAX) begin
        digit_r <= 4'd0;
      end else begin
        digit_r <= digit_r + 4'd1;
      end
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit = digit_r;
  assign carry = inc && (digit_r == BCD_MAX);

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
//   Watches a free-running modulo counter. Each qualified sample must equal
//   the previous sample + 1 (mod MODULUS); a skip, stall or out-of-range
//   value raises a one-cycle mismatch and sets err. Clean MODULUS-1 -> 0
//   transitions pulse wrap_pulse and advance a packed-BCD wrap tally.
// Optional feature (macro COUNT_SEQ_MONITOR_RESYNC_EN)
//   defined   : in ERROR the next valid sample is taken as a new reference
//               (unchecked), err clears and tracking resumes.
//   undefined : ERROR is sticky until reset; samples are ignored.
// Ports
//   clk        in  1              clock, posedge
//   rst        in  1              synchronous active-low reset
//   count      in  WIDTH          observed counter value
//   valid      in  1              count is a fresh sample this cycle
//   wraps_bcd  out 4*WRAP_DIGITS  BCD wrap tally, digit 0 in [3:0]
//   wrap_pulse out 1              one cycle per detected wrap
//   mismatch   out 1              one cycle per failed check
//   err        out 1              error status
//   state      out 2              FSM state (0 idle, 1 track, 2 error)
module count_seq_monitor
  import count_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int WRAP_DIGITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count,
  input  logic                     valid,
  output logic [4*WRAP_DIGITS-1:0] wraps_bcd,
  output logic                     wrap_pulse,
  output logic                     mismatch,
  output logic                     err,
  output logic [1:0]               state
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  state_e           state_r;
  logic [WIDTH-1:0] prev_r;

  logic [WIDTH-1:0] expected_s;
  logic             at_max_s;
  logic             in_range_s;
  logic             match_s;
  logic             wrap_s;

  logic [WRAP_DIGITS:0] chain_s;
  logic                 tally_carry_unused_s;

  // Compare the incoming sample against the value the counter should show next.
  always_comb begin
    expected_s = '0;
    at_max_s   = 1'b0;
    if (prev_r == MAX_VAL) begin
      expected_s = '0;
      at_max_s   = 1'b1;
    end else begin
      expected_s = prev_r + WIDTH'(1);
      at_max_s   = 1'b0;
    end
    // extra top bit keeps MODULUS == 2**WIDTH representable
    in_range_s = ({1'b0, count} < MOD_W);
    match_s    = in_range_s && (count == expected_s);
    if (valid && (state_r == ST_TRACK) && match_s && at_max_s) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Monitor FSM with reference register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      prev_r     <= '0;
      wrap_pulse <= 1'b0;
      mismatch   <= 1'b0;
      err        <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      mismatch   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid) begin
            // first sample only seeds the reference, unless it is illegal
            prev_r <= count;
            if (in_range_s) begin
              state_r <= ST_TRACK;
            end else begin
              state_r  <= ST_ERROR;
              mismatch <= 1'b1;
              err      <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (valid) begin
            prev_r <= count;
            if (match_s) begin
              wrap_pulse <= at_max_s;
            end else begin
              state_r  <= ST_ERROR;
              mismatch <= 1'b1;
              err      <= 1'b1;
            end
          end else begin
            state_r <= ST_TRACK;
          end
        end
        ST_ERROR: begin
`ifdef COUNT_SEQ_MONITOR_RESYNC_EN
          if (valid) begin
            // take this sample as the new reference without checking it
            prev_r  <= count;
            err     <= 1'b0;
            state_r <= ST_TRACK;
          end else begin
            state_r <= ST_ERROR;
          end
`else
          // sticky until reset; samples are ignored
          state_r <= ST_ERROR;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign state = state_r;

  // Wrap tally: digit 0 advances on a clean wrap, carries ripple upward.
  assign chain_s[0] = wrap_s;

  for (genvar i = 0; i < WRAP_DIGITS; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk   (clk),
      .rst   (rst),
      .inc   (chain_s[i]),
      .digit (wraps_bcd[4*i +: 4]),
      .carry (chain_s[i+1])
    );
  end

  // carry out of the top decade: the tally silently rolls over to zero
  assign tally_carry_unused_s = chain_s[WRAP_DIGITS];

endmodule
